// File: rtl/i2c_master_pkg.sv
// rtl/i2c_master_pkg.sv - shared state encoding and constants for i2c_master
package i2c_master_pkg;

   localparam int CLK_DIV_DEFAULT = 1;
   localparam int BIT_CNT_W       = 3;

   typedef logic [3:0] state_t;

   localparam state_t ST_IDLE      = 4'd0;
   localparam state_t ST_START     = 4'd1;
   localparam state_t ST_ADDR      = 4'd2;
   localparam state_t ST_ADDR_ACK  = 4'd3;
   localparam state_t ST_WRITE     = 4'd4;
   localparam state_t ST_WRITE_ACK = 4'd5;
   localparam state_t ST_READ      = 4'd6;
   localparam state_t ST_READ_ACK  = 4'd7;
   localparam state_t ST_HOLD      = 4'd8;
   localparam state_t ST_STOP      = 4'd9;

endpackage

// File: rtl/i2c_clk_gen.sv
// rtl/i2c_clk_gen.sv - quarter-bit tick and 2-bit phase counter for i2c_master
module i2c_clk_gen
   import i2c_master_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run_i,
   output logic       tick_o,
   output logic [1:0] phase_o
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0] div_q, div_d;
   logic [1:0]    phase_q, phase_d;

   assign tick_o  = run_i && (div_q == DW'(CLK_DIV - 1));
   assign phase_o = phase_q;

   // Counters sit at zero while stopped so every bit starts on a fresh quarter 0.
   always_comb begin
      div_d   = div_q;
      phase_d = phase_q;
      if (!run_i) begin
         div_d   = '0;
         phase_d = '0;
      end else if (tick_o) begin
         div_d   = '0;
         phase_d = phase_q + 2'd1;
      end else begin
         div_d = div_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q   <= '0;
         phase_q <= '0;
      end else begin
         div_q   <= div_d;
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - single-byte I2C master; I2C_MASTER_LOOPBACK_EN adds an internal loopback slave
module i2c_master
   import i2c_master_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_bit,
   input  logic       stop_bit,
   input  logic [6:0] addr,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   inout  wire        sda,
   output logic       scl
);

   state_t               state_q, state_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [7:0]           shift_q, shift_d;
   logic [7:0]           rx_q, rx_d;
   logic [7:0]           data_q, data_d;
   logic [7:0]           data_out_q, data_out_d;
   logic [6:0]           addr_q, addr_d;
   logic                 start_q;
   logic                 restart_q, restart_d;

   logic                 tick;
   logic [1:0]           phase;
   logic                 start_edge;
   logic                 bit_end;
   logic                 sample;
   logic                 last_bit;
   logic                 scl_bit;
   logic                 rx_bit;
   logic                 sda_low;

   i2c_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .clk     (clk),
      .rst     (rst),
      .run_i   ((state_q != ST_IDLE) && (state_q != ST_HOLD)),
      .tick_o  (tick),
      .phase_o (phase)
   );

   assign start_edge = start_bit && !start_q;
   assign bit_end    = tick && (phase == 2'd3);
   assign sample     = tick && (phase == 2'd1);
   assign last_bit   = (bit_cnt_q == 3'd7);
   assign scl_bit    = phase[0] ^ phase[1];
   assign data_out   = data_out_q;
   assign sda        = sda_low ? 1'b0 : 1'bz;

`ifdef I2C_MASTER_LOOPBACK_EN
   logic [7:0] lb_q, lb_d;

   assign rx_bit = lb_q[3'd7 - bit_cnt_q];

   always_comb begin
      lb_d = lb_q;
      if ((state_q == ST_WRITE) && bit_end && last_bit) lb_d = data_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) lb_q <= 8'h00;
      else      lb_q <= lb_d;
   end
`else
   logic sda_in;

   // Anything other than a solid 0 on the pin counts as a released (high) line.
   assign sda_in = (sda === 1'b0) ? 1'b0 : 1'b1;
   assign rx_bit = sda_in;
`endif

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      rx_d       = rx_q;
      addr_d     = addr_q;
      data_d     = data_q;
      data_out_d = data_out_q;
      restart_d  = restart_q;
      case (state_q)
         ST_IDLE: if (start_edge) begin
            state_d   = ST_START;
            addr_d    = addr;
            data_d    = data_in;
            restart_d = 1'b0;
         end
         ST_START: if (bit_end) begin
            state_d   = ST_ADDR;
            shift_d   = {addr_q, addr_q[0]};
            bit_cnt_d = '0;
         end
         ST_ADDR, ST_WRITE: if (bit_end) begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (last_bit) state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_WRITE_ACK;
         end
         ST_ADDR_ACK: if (bit_end) begin
            if (addr_q[0]) begin
               state_d = ST_READ;
               rx_d    = '0;
            end else begin
               state_d = ST_WRITE;
               shift_d = data_q;
            end
         end
         ST_READ: begin
            if (sample) rx_d = {rx_q[6:0], rx_bit};
            if (bit_end) begin
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (last_bit) state_d = ST_READ_ACK;
            end
         end
         ST_READ_ACK, ST_WRITE_ACK: if (bit_end) begin
            if (state_q == ST_READ_ACK) data_out_d = rx_q;
            state_d = stop_bit ? ST_STOP : ST_HOLD;
         end
         ST_HOLD: begin
            if (stop_bit) begin
               state_d = ST_STOP;
            end else if (start_edge) begin
               state_d   = ST_START;
               addr_d    = addr;
               data_d    = data_in;
               restart_d = 1'b1;
            end
         end
         ST_STOP: if (bit_end) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // A repeated START enters with scl low, so quarter 0 keeps it low before raising it.
   always_comb begin
      scl     = 1'b1;
      sda_low = 1'b0;
      case (state_q)
         ST_START: begin
            scl     = (phase == 2'd0) ? !restart_q : (phase != 2'd3);
            sda_low = phase[1];
         end
         ST_ADDR, ST_WRITE: begin
            scl     = scl_bit;
            sda_low = !shift_q[7];
         end
         ST_ADDR_ACK, ST_READ, ST_READ_ACK, ST_WRITE_ACK: scl = scl_bit;
         ST_HOLD: begin
            scl     = 1'b0;
            sda_low = 1'b1;
         end
         ST_STOP: begin
            scl     = (phase != 2'd0);
            sda_low = !phase[1];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         rx_q       <= '0;
         data_q     <= '0;
         data_out_q <= 8'h00;
         addr_q     <= '0;
         start_q    <= 1'b0;
         restart_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         rx_q       <= rx_d;
         data_q     <= data_d;
         data_out_q <= data_out_d;
         addr_q     <= addr_d;
         start_q    <= start_bit;
         restart_q  <= restart_d;
      end
   end

endmodule

// File: tb/tb_i2c_master.sv
// tb/tb_i2c_master.sv - scoreboard bench for i2c_master with a bus-level slave and decoder
module tb_i2c_master;

   typedef struct {
      logic [7:0] abyte;
      logic       rd;
      logic [7:0] dbyte;
      logic       ack_a;
      logic       ack_d;
      logic [7:0] dout;
   } exp_t;

   typedef struct {
      logic       ack_a;
      logic       ack_d;
      logic [7:0] rbyte;
   } scfg_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_bit;
   logic       stop_bit;
   logic [6:0] addr;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       scl;
   wire        sda_w;
   logic       slave_low = 1'b0;
   logic       bus_reset = 1'b0;

   int   checks = 0;
   int   failures = 0;
   int   frames = 0;
   int   stops = 0;
   int   cyc = 0;
   logic [7:0] last_rd = 8'h00;

   exp_t  exp_q[$];
   scfg_t slave_q[$];

   assign sda_w = slave_low ? 1'b0 : 1'bz;
   pullup (sda_w);

   always #5 clk = ~clk;

   i2c_master dut (
      .clk      (clk),
      .rst      (rst),
      .start_bit(start_bit),
      .stop_bit (stop_bit),
      .addr     (addr),
      .data_in  (data_in),
      .data_out (data_out),
      .sda      (sda_w),
      .scl      (scl)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Issue one transaction; the expected bus frame is derived from the addressing rules.
   task automatic issue(input logic [6:0] a, input logic [7:0] d, input logic stp, input logic push_exp);
      scfg_t c;
      exp_t  e;
      c.ack_a = ($urandom_range(0, 3) != 0);
      c.ack_d = ($urandom_range(0, 3) != 0);
      c.rbyte = 8'($urandom);
      slave_q.push_back(c);
      if (push_exp) begin
         e.abyte = {a, a[0]};
         e.rd    = a[0];
         e.ack_a = c.ack_a;
         e.ack_d = c.ack_d;
         e.dbyte = a[0] ? c.rbyte : d;
         if (a[0]) last_rd = c.rbyte;
         e.dout  = last_rd;
         exp_q.push_back(e);
      end
      addr      = a;
      data_in   = d;
      stop_bit  = stp;
      start_bit = 1'b1;
      step(1);
      start_bit = 1'b0;
   endtask

   task automatic wait_frames(input int target, input int budget, input string name);
      int n = 0;
      while (frames < target && n < budget) begin
         step(1);
         n++;
      end
      chk(name, 32'(frames >= target), 32'd1);
   endtask

   task automatic finalize(input logic [7:0] bits[$], input logic by_stop, input int dur);
      exp_t       e;
      logic [7:0] ab, db;
      frames++;
      if (exp_q.size() == 0) begin
         chk("unexpected_frame", 32'd1, 32'd0);
         return;
      end
      e = exp_q.pop_front();
      chk("frame_bits", 32'(bits.size()), 32'd18);
      if (bits.size() != 18) return;
      for (int i = 0; i < 8; i++) begin
         ab[7-i] = bits[i];
         db[7-i] = bits[9+i];
      end
      chk("addr_byte", {24'd0, ab}, {24'd0, e.abyte});
      chk("addr_ack", {31'd0, bits[8]}, {31'd0, !e.ack_a});
      chk("data_byte", {24'd0, db}, {24'd0, e.dbyte});
      chk("data_ack", {31'd0, bits[17]}, {31'd0, e.rd ? 1'b1 : !e.ack_d});
      chk("data_out", {24'd0, data_out}, {24'd0, e.dout});
      if (by_stop) chk("frame_len", 32'(dur), 32'd76);
   endtask

   // Bus decoder and slave: samples at the falling clk edge, away from DUT updates.
   initial begin
      logic       pc = 1'b1, ps = 1'b1, c, s;
      logic       in_frame = 1'b0;
      int         nfall = 0, slot, t0 = 0;
      logic [7:0] bits[$];
      scfg_t      cfg;
      cfg.ack_a = 1'b1;
      cfg.ack_d = 1'b1;
      cfg.rbyte = 8'hFF;
      forever begin
         @(negedge clk);
         cyc++;
         c = scl;
         s = sda_w;
         if (bus_reset) begin
            in_frame  = 1'b0;
            nfall     = 0;
            bits.delete();
            slave_low = 1'b0;
         end else if (pc && c && ps && !s) begin
            if (in_frame) finalize(bits, 1'b0, 0);
            in_frame = 1'b1;
            nfall    = 0;
            bits.delete();
            t0 = cyc;
            if (slave_q.size() > 0) cfg = slave_q.pop_front();
         end else if (pc && c && !ps && s) begin
            stops++;
            if (in_frame) finalize(bits, 1'b1, cyc - t0);
            in_frame  = 1'b0;
            slave_low = 1'b0;
         end else if (!pc && c && in_frame) begin
            if (nfall >= 1 && nfall <= 18) bits.push_back(s);
         end else if (pc && !c && in_frame) begin
            nfall++;
            slot = nfall - 1;
            if (slot == 8)
               slave_low = cfg.ack_a;
            else if (slot >= 9 && slot <= 16 && bits.size() >= 8 && bits[7])
               slave_low = !cfg.rbyte[16-slot];
            else if (slot == 17 && bits.size() >= 8 && !bits[7])
               slave_low = cfg.ack_d;
            else
               slave_low = 1'b0;
         end
         pc = c;
         ps = s;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_frames, n_stops;
      logic [6:0] a;
      rst = 1'b0; start_bit = 1'b0; stop_bit = 1'b1; addr = '0; data_in = '0;
      step(1);
      chk("reset_scl", {31'd0, scl}, 32'd1);
      chk("reset_sda", {31'd0, sda_w}, 32'd1);
      chk("reset_data_out", {24'd0, data_out}, 32'd0);
      rst = 1'b1;
      step(2);

      issue(7'h50, 8'hAA, 1'b1, 1'b1);
      wait_frames(1, 90, "write_done_90clk");
      step(3);
      chk("idle_scl", {31'd0, scl}, 32'd1);
      chk("idle_sda", {31'd0, sda_w}, 32'd1);

      for (int i = 0; i < 10; i++) begin
         issue(7'($urandom), 8'($urandom), 1'b1, 1'b1);
         wait_frames(frames + 1, 120, "rand_done");
         step(1 + $urandom_range(0, 4));
      end

      n_frames = frames;
      n_stops  = stops;
      issue(7'($urandom), 8'($urandom), 1'b0, 1'b1);
      step(110);
      chk("hold_scl", {31'd0, scl}, 32'd0);
      chk("hold_sda", {31'd0, sda_w}, 32'd0);
      chk("hold_no_stop", 32'(stops), 32'(n_stops));
      issue(7'($urandom), 8'($urandom), 1'b0, 1'b1);
      stop_bit = 1'b1;
      wait_frames(n_frames + 2, 120, "restart_done");
      chk("restart_one_stop", 32'(stops), 32'(n_stops + 1));
      step(3);

      n_frames = frames;
      a = 7'($urandom);
      issue(a, 8'($urandom), 1'b1, 1'b1);
      start_bit = 1'b1;
      step(199);
      start_bit = 1'b0;
      step(20);
      chk("held_start_once", 32'(frames), 32'(n_frames + 1));

      a = {6'($urandom), 1'b0};
      issue(a, 8'($urandom), 1'b1, 1'b0);
      step(50);
      bus_reset = 1'b1;
      rst = 1'b0;
      last_rd = 8'h00;
      step(1);
      chk("abort_scl", {31'd0, scl}, 32'd1);
      chk("abort_sda", {31'd0, sda_w}, 32'd1);
      chk("abort_data_out", {24'd0, data_out}, 32'd0);
      step(1);
      rst = 1'b1;
      step(3);
      bus_reset = 1'b0;
      step(2);

      n_frames = frames;
      issue({6'($urandom), 1'b1}, 8'($urandom), 1'b1, 1'b1);
      wait_frames(n_frames + 1, 90, "post_abort_read");
      step(2);
      issue({6'($urandom), 1'b0}, 8'($urandom), 1'b1, 1'b1);
      wait_frames(n_frames + 2, 90, "post_abort_write");
      step(5);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
